arm_mc_ctrl: RTL and testbench
==============================

# arm_mc_ctrl

Multicycle control unit for the ARM core. It sits directly upstream of the immediate extender and drives `ImmSrc` along with every other datapath control strobe. A main FSM sequences each instruction through fetch, decode, execute, memory and writeback. The block also holds the NZCV flag register and the condition-execution logic, and stalls on a memory-ready handshake.

## Interface
Parameters: none.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Cond` in 4: `Instr[31:28]`.
- `Op` in 2: `Instr[27:26]`.
- `Funct` in 6: `Instr[25:20]`.
- `Rd` in 4: `Instr[15:12]`.
- `ALUFlags` in 4: ALU NZCV result.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `IRWrite` out 1: instruction register enable.
- `RegWrite` out 1: register-file write enable.
- `MemWrite` out 1: data-memory write strobe.
- `AdrSrc` out 1: memory address select, 0 = PC, 1 = ALU result.
- `ALUSrcA` out 1: 0 = Rn, 1 = PC.
- `ALUSrcB` out 2: 00 = Rm, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `ImmSrc` out 2: extender mode.
- `RegSrc` out 2: register-address select.
- `ALUControl` out 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.

## Operation
**States** (4-bit codes): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 are illegal and recover to FETCH.

**Per-state outputs and transitions.** Any strobe not listed is 0.
- FETCH: `IRWrite=MemReady`, `NextPC=MemReady`, `AdrSrc=0`, `ALUSrcA=1`, `ALUSrcB=10`, `ResultSrc=10`. Goes to DECODE when `MemReady`, otherwise stays in FETCH.
- DECODE: `ALUSrcA=1`, `ALUSrcB=10`, `ResultSrc=10`. Latches `cond_ex`. Next state by `Op`:
  - 01 → MEMADR
  - 00 with `Funct[5]=1` → EXECI
  - 00 with `Funct[5]=0` → EXECR
  - 10 → BRANCH
  - 11 → FETCH (NOP)
- MEMADR: `ALUSrcA=0`, `ALUSrcB=01`. Goes to MEMRD if `Funct[0]`, else MEMWR.
- MEMRD: `AdrSrc=1`, `ResultSrc=00`. Goes to MEMWB on `MemReady`.
- MEMWB: `ResultSrc=01`, `RegW=1`. Goes to FETCH.
- MEMWR: `AdrSrc=1`, `MemW=MemReady`. Goes to FETCH on `MemReady`.
- EXECR: `ALUSrcA=0`, `ALUSrcB=00`, `ALUOp=1`. Goes to ALUWB.
- EXECI: `ALUSrcA=0`, `ALUSrcB=01`, `ALUOp=1`. Goes to ALUWB.
- ALUWB: `ResultSrc=00`, `RegW=1`. Goes to FETCH.
- BRANCH: `ALUSrcA=0`, `ALUSrcB=01`, `ResultSrc=10`, `Branch=1`. Goes to FETCH.

**Output gating**
- `RegWrite = RegW & cond_ex`
- `MemWrite = MemW & cond_ex`
- `PCWrite = NextPC | (cond_ex & (Branch | (RegW & Rd==15)))`

**Decode outputs** (combinational from the instruction fields)
- `ImmSrc = Op`: 00 = 8-bit zero-extend, 01 = 12-bit zero-extend, 10 = branch.
- `RegSrc = {Op==01, Op==10}`.

**ALU decoder**
- `ALUOp=0`: `ALUControl=00`, `FlagW=00`.
- `ALUOp=1`, by `Funct[4:1]`: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP. CMP uses SUB and suppresses `RegW` in ALUWB.
- Any other `Funct[4:1]`: `ALUControl=00`, `FlagW=00`.
- `FlagW[1] = Funct[0]`.
- `FlagW[0] = Funct[0] & (ADD | SUB | CMP)`.

**Flags**
- The NZCV register updates at the end of EXECR/EXECI cycles.
- NZ load when `FlagW[1] & cond_ex`; CV load when `FlagW[0] & cond_ex`.

**Condition check** (`cond_ex`, evaluated against the registered flags)
- 0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC
- 1000 HI, 1001 LS, 1010 GE, 1011 LT, 1100 GT, 1101 LE, 1110 AL
- 1111 evaluates false

## Timing
- **Reset (async assert):** state=FETCH, NZCV=0000, `cond_ex=0`.
  - All strobes are 0, except `IRWrite`/`PCWrite`, which follow `MemReady` once in FETCH.
  - Reset asserted mid-instruction aborts it, with no further writes.
- **Latency** with `MemReady` held high:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
- **Stalls:** each cycle with `MemReady=0` in FETCH, MEMRD or MEMWR adds one cycle. During a stall the state and all write strobes are held; no write occurs twice.
- **Flag timing:** flags written in EXEC take effect from the next instruction's DECODE onward. `cond_ex` is stable from DECODE until that instruction's last cycle.
- **Moore outputs:** outputs depend on the registered state plus the instruction fields and `MemReady`. There is no path from `ALUFlags` to any output in the same cycle.

## Structure
- Shared header `arm_defs.vh` holds:
  - state codes
  - `ImmSrc` codes (shared with the extender)
  - `ALUSrcB`, `ResultSrc` and `ALUControl` encodings
  - condition-code constants
- Sub-module `arm_cond_unit` contains the NZCV register, `cond_ex` latch and condition decode.
- The top level holds the main FSM and the ALU decoder.

## Test plan
- **ADD immediate:** `Instr=E2811005`, `MemReady=1`. States FETCH→DECODE→EXECI→ALUWB. Requires `ImmSrc=00`, `ALUSrcB=01`, `ALUControl=00`, and `RegWrite=1` only in ALUWB.
- **LDR with stall:** `E5912004`, `MemReady` low for 2 cycles in MEMRD. Requires 7 cycles total, `AdrSrc=1` held, `ImmSrc=01`, and `RegWrite=1` once, in MEMWB.
- **Taken branch:** `BEQ` (`Cond=0000`) after `SUBS` produces Z=1. BRANCH asserts `PCWrite=1`, `ImmSrc=10`. Repeat with Z=0: `PCWrite=0` in BRANCH.
- **CMP:** `E3510000` with `ALUFlags=0100`. Requires Z=1 in the register the next cycle, `ALUControl=01`, and `RegWrite=0` in ALUWB.
- **Reset mid-MEMWR:** assert `rst_n=0` with `MemReady=0` in MEMWR. Requires immediate state=FETCH, `MemWrite=0`, and flags 0000.
- **Illegal op and condition:** `Op=11` returns to FETCH after DECODE with no writes. `Cond=1111` suppresses `RegWrite`, `MemWrite` and flag updates.

Source files
------------

// File: rtl/arm_mc_ctrl_pkg.sv
// Shared definitions for the multicycle ARM control unit: state codes, datapath
// select encodings, ALU commands and the condition-code evaluator.
package arm_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // Extender modes, shared with the immediate extender.
  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_BR = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing command field, Funct[4:1].
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // nzcv is ordered {N, Z, C, V}; the NV code never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register and the per-instruction condition-execute latch.
// Flags are only ever updated by an instruction whose own condition passed.
module arm_cond_unit
  import arm_mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       cond_latch,
  output logic       cond_ex
);

  logic [3:0] nzcv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv    <= 4'b0000;
      cond_ex <= 1'b0;
    end else begin
      if (flag_w[1] && cond_ex) nzcv[3:2] <= alu_flags[3:2];
      if (flag_w[0] && cond_ex) nzcv[1:0] <= alu_flags[1:0];
      // Sampled once per instruction so later flag writes cannot change it.
      if (cond_latch) cond_ex <= cond_eval(cond, nzcv);
    end
  end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM control unit: main FSM, ALU decoder and write-strobe gating.
// Outputs depend only on the registered state, instruction fields and MemReady.
module arm_mc_ctrl
  import arm_mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  state_t     state, next_state;
  logic       next_pc, reg_w, mem_w, branch, alu_op;
  logic [1:0] flag_w;
  logic       cond_ex;
  logic       is_cmp;

  assign is_cmp = (Funct[4:1] == CMD_CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // MemReady handshake: a memory access issued in FETCH, MEMRD or MEMWR completes
  // in the cycle MemReady is high; while it is low the state and strobes hold.
  always_comb begin
    next_state = state;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RM;
    ResultSrc  = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        IRWrite   = MemReady;
        next_pc   = MemReady;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (MemReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        case (Op)
          2'b01:   next_state = S_MEMADR;
          2'b00:   next_state = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        next_state = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        if (MemReady) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_RDATA;
        reg_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = MemReady;
        if (MemReady) next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcB    = SRCB_RM;
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        reg_w      = ~is_cmp;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALU;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // CMP is a flag-setting SUB; logical ops never touch C/V.
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          flag_w     = {Funct[0], Funct[0]};
        end
        CMD_SUB, CMD_CMP: begin
          ALUControl = ALU_SUB;
          flag_w     = {Funct[0], Funct[0]};
        end
        CMD_AND: begin
          ALUControl = ALU_AND;
          flag_w     = {Funct[0], 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALU_ORR;
          flag_w     = {Funct[0], 1'b0};
        end
        default: begin
          ALUControl = ALU_ADD;
          flag_w     = 2'b00;
        end
      endcase
    end
  end

  arm_cond_unit u_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .cond       (Cond),
    .alu_flags  (ALUFlags),
    .flag_w     (flag_w),
    .cond_latch (state == S_DECODE),
    .cond_ex    (cond_ex)
  );

  assign RegWrite = reg_w & cond_ex;
  assign MemWrite = mem_w & cond_ex;
  assign PCWrite  = next_pc | (cond_ex & (branch | (reg_w & (Rd == 4'd15))));

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Directed bench for arm_mc_ctrl: instruction sequences with hand-derived
// state traces and strobe values, including stalls and an aborting reset.
module tb_arm_mc_ctrl;
  import arm_mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  arm_mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: expected state per cycle plus the MemReady to drive in it.
  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  logic [3:0] o_state[32];
  logic [3:0] o_nzcv[32];
  logic       o_pcw[32], o_irw[32], o_rw[32], o_mw[32], o_adr[32];
  logic [1:0] o_srcb[32], o_rsrc[32], o_imm[32], o_regsrc[32], o_aluc[32];
  int         n_cyc, rw_cnt, mw_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_instr(input logic [31:0] instr);
    Cond  = instr[31:28];
    Op    = instr[27:26];
    Funct = instr[25:20];
    Rd    = instr[15:12];
  endtask

  task automatic push(input logic [3:0] st, input logic rdy);
    exp_q.push_back(st);
    rdy_q.push_back(rdy);
  endtask

  // Drive MemReady for one cycle, sample on the falling edge, return after the rising edge.
  task automatic step(input logic rdy, input int idx);
    MemReady = rdy;
    @(negedge clk);
    o_state[idx]  = dut.state;
    o_nzcv[idx]   = dut.u_cond.nzcv;
    o_pcw[idx]    = PCWrite;
    o_irw[idx]    = IRWrite;
    o_rw[idx]     = RegWrite;
    o_mw[idx]     = MemWrite;
    o_adr[idx]    = AdrSrc;
    o_srcb[idx]   = ALUSrcB;
    o_rsrc[idx]   = ResultSrc;
    o_imm[idx]    = ImmSrc;
    o_regsrc[idx] = RegSrc;
    o_aluc[idx]   = ALUControl;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [31:0] instr, input logic [3:0] flags);
    logic [3:0] e;
    logic       r;
    set_instr(instr);
    ALUFlags = flags;
    n_cyc  = 0;
    rw_cnt = 0;
    mw_cnt = 0;
    while (exp_q.size() > 0 && n_cyc < 32) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      step(r, n_cyc);
      check($sformatf("%s state c%0d", name, n_cyc), {28'd0, o_state[n_cyc]}, {28'd0, e});
      rw_cnt += int'(o_rw[n_cyc]);
      mw_cnt += int'(o_mw[n_cyc]);
      n_cyc++;
    end
    check($sformatf("%s back to FETCH", name), {28'd0, dut.state}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    MemReady = 1'b0;
    ALUFlags = 4'b0000;
    set_instr(32'h0000_0000);
    #2;
    check("reset state", {28'd0, dut.state}, 32'd0);
    check("reset nzcv", {28'd0, dut.u_cond.nzcv}, 32'd0);
    check("reset IRWrite ready0", {31'd0, IRWrite}, 32'd0);
    check("reset PCWrite ready0", {31'd0, PCWrite}, 32'd0);
    check("reset RegWrite", {31'd0, RegWrite}, 32'd0);
    check("reset MemWrite", {31'd0, MemWrite}, 32'd0);
    MemReady = 1'b1;
    #1;
    check("reset IRWrite ready1", {31'd0, IRWrite}, 32'd1);
    check("reset PCWrite ready1", {31'd0, PCWrite}, 32'd1);
    MemReady = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD R1, R1, #5
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_EXECI, 1); push(S_ALUWB, 1);
    run("add", 32'hE281_1005, 4'b0000);
    check("add IRWrite fetch", {31'd0, o_irw[0]}, 32'd1);
    check("add PCWrite fetch", {31'd0, o_pcw[0]}, 32'd1);
    check("add srcb fetch", {30'd0, o_srcb[0]}, 32'd2);
    check("add ImmSrc", {30'd0, o_imm[2]}, 32'd0);
    check("add ALUSrcB", {30'd0, o_srcb[2]}, 32'd1);
    check("add ALUControl", {30'd0, o_aluc[2]}, 32'd0);
    check("add RegWrite exec", {31'd0, o_rw[2]}, 32'd0);
    check("add RegWrite aluwb", {31'd0, o_rw[3]}, 32'd1);
    check("add RegWrite count", rw_cnt, 32'd1);
    check("add PCWrite aluwb", {31'd0, o_pcw[3]}, 32'd0);

    // LDR R2, [R1, #4] with two wait cycles in MEMRD
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_MEMADR, 1);
    push(S_MEMRD, 0); push(S_MEMRD, 0); push(S_MEMRD, 1); push(S_MEMWB, 1);
    run("ldr", 32'hE591_2004, 4'b0000);
    check("ldr cycles", n_cyc, 32'd7);
    check("ldr ImmSrc", {30'd0, o_imm[2]}, 32'd1);
    check("ldr RegSrc", {30'd0, o_regsrc[2]}, 32'd2);
    check("ldr AdrSrc stall0", {31'd0, o_adr[3]}, 32'd1);
    check("ldr AdrSrc stall1", {31'd0, o_adr[4]}, 32'd1);
    check("ldr AdrSrc done", {31'd0, o_adr[5]}, 32'd1);
    check("ldr RegWrite memwb", {31'd0, o_rw[6]}, 32'd1);
    check("ldr ResultSrc memwb", {30'd0, o_rsrc[6]}, 32'd1);
    check("ldr RegWrite count", rw_cnt, 32'd1);
    check("ldr MemWrite count", mw_cnt, 32'd0);

    // SUBS R3, R1, R2 producing Z=1, then BEQ taken
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_EXECR, 1); push(S_ALUWB, 1);
    run("subs z1", 32'hE051_3002, 4'b0100);
    check("subs z1 ALUControl", {30'd0, o_aluc[2]}, 32'd1);
    check("subs z1 nzcv", {28'd0, o_nzcv[3]}, 32'h4);
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_BRANCH, 1);
    run("beq taken", 32'h0A00_0004, 4'b0000);
    check("beq taken PCWrite", {31'd0, o_pcw[2]}, 32'd1);
    check("beq taken ImmSrc", {30'd0, o_imm[2]}, 32'd2);
    check("beq taken RegSrc", {30'd0, o_regsrc[2]}, 32'd1);
    check("beq taken ALUSrcB", {30'd0, o_srcb[2]}, 32'd1);
    check("beq taken RegWrite count", rw_cnt, 32'd0);

    // SUBS producing Z=0, then BEQ not taken
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_EXECR, 1); push(S_ALUWB, 1);
    run("subs z0", 32'hE051_3002, 4'b0000);
    check("subs z0 nzcv", {28'd0, o_nzcv[3]}, 32'h0);
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_BRANCH, 1);
    run("beq not taken", 32'h0A00_0004, 4'b0000);
    check("beq not taken PCWrite", {31'd0, o_pcw[2]}, 32'd0);

    // CMP R1, #0 with Z result
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_EXECI, 1); push(S_ALUWB, 1);
    run("cmp", 32'hE351_0000, 4'b0100);
    check("cmp ALUControl", {30'd0, o_aluc[2]}, 32'd1);
    check("cmp nzcv before", {28'd0, o_nzcv[2]}, 32'h0);
    check("cmp nzcv after", {28'd0, o_nzcv[3]}, 32'h4);
    check("cmp RegWrite aluwb", {31'd0, o_rw[3]}, 32'd0);

    // Op=11 falls straight back to FETCH
    push(S_FETCH, 1); push(S_DECODE, 1);
    run("nop", 32'hEC00_0000, 4'b1111);
    check("nop RegWrite count", rw_cnt, 32'd0);
    check("nop MemWrite count", mw_cnt, 32'd0);
    check("nop PCWrite decode", {31'd0, o_pcw[1]}, 32'd0);

    // ADDS with the never-execute condition
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_EXECR, 1); push(S_ALUWB, 1);
    run("adds nv", 32'hF091_2003, 4'b1001);
    check("adds nv RegWrite", {31'd0, o_rw[3]}, 32'd0);
    check("adds nv nzcv", {28'd0, o_nzcv[3]}, 32'h4);

    // STR R2, [R1, #4]
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_MEMADR, 1); push(S_MEMWR, 1);
    run("str", 32'hE581_2004, 4'b0000);
    check("str cycles", n_cyc, 32'd4);
    check("str MemWrite", {31'd0, o_mw[3]}, 32'd1);
    check("str MemWrite count", mw_cnt, 32'd1);
    check("str AdrSrc", {31'd0, o_adr[3]}, 32'd1);

    push(S_FETCH, 1); push(S_DECODE, 1); push(S_MEMADR, 1); push(S_MEMWR, 1);
    run("str nv", 32'hF581_2004, 4'b0000);
    check("str nv MemWrite count", mw_cnt, 32'd0);

    // STR stalled in MEMWR, then reset aborts it
    set_instr(32'hE581_2004);
    step(1'b1, 0);
    step(1'b1, 1);
    step(1'b1, 2);
    step(1'b0, 3);
    check("abort state stalled", {28'd0, o_state[3]}, {28'd0, S_MEMWR});
    check("abort MemWrite stalled", {31'd0, o_mw[3]}, 32'd0);
    check("abort nzcv before", {28'd0, o_nzcv[3]}, 32'h4);
    MemReady = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort state", {28'd0, dut.state}, 32'd0);
    check("abort MemWrite", {31'd0, MemWrite}, 32'd0);
    check("abort RegWrite", {31'd0, RegWrite}, 32'd0);
    check("abort PCWrite", {31'd0, PCWrite}, 32'd0);
    check("abort nzcv", {28'd0, dut.u_cond.nzcv}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // BEQ after reset: cleared Z means not taken
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_BRANCH, 1);
    run("beq post reset", 32'h0A00_0004, 4'b0000);
    check("beq post reset PCWrite", {31'd0, o_pcw[2]}, 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
